// File: rtl/sync_vg_pkg.sv
// Shared types and the preset timing table for the multi-mode video timing generator.
// Each mode's geometry is reduced to the counter boundaries the generator compares against.
package sync_vg_pkg;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_1080P60 = 2'd0,
    MODE_720P60  = 2'd1,
    MODE_480P60  = 2'd2,
    MODE_800X600 = 2'd3
  } mode_t;

  typedef struct packed {
    cnt_t h_act;
    cnt_t h_fp;
    cnt_t h_sync;
    cnt_t h_bp;
    cnt_t h_total;
    cnt_t v_act;
    cnt_t v_fp;
    cnt_t v_sync;
    cnt_t v_bp;
    cnt_t v_total;
    logic hpol;  // 1 = active-high sync
    logic vpol;
  } timing_t;

  // Region boundaries: sync is [0,*s_end), active is [*a_beg,*a_end), *_last is the wrap point.
  typedef struct packed {
    cnt_t h_last;
    cnt_t hs_end;
    cnt_t ha_beg;
    cnt_t ha_end;
    cnt_t v_last;
    cnt_t vs_end;
    cnt_t va_beg;
    cnt_t va_end;
  } geom_t;

  localparam timing_t TIMING [4] = '{
    '{12'd1920, 12'd88,  12'd44,  12'd148, 12'd2200,
      12'd1080, 12'd4,   12'd5,   12'd36,  12'd1125, 1'b1, 1'b1},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd1650,
      12'd720,  12'd5,   12'd5,   12'd20,  12'd750,  1'b1, 1'b1},
    '{12'd720,  12'd16,  12'd62,  12'd60,  12'd858,
      12'd480,  12'd9,   12'd6,   12'd30,  12'd525,  1'b0, 1'b0},
    '{12'd800,  12'd40,  12'd128, 12'd88,  12'd1056,
      12'd600,  12'd1,   12'd4,   12'd23,  12'd628,  1'b1, 1'b1}
  };

  function automatic timing_t get_timing(input mode_t m);
    return TIMING[m];
  endfunction

  function automatic geom_t get_geom(input mode_t m);
    timing_t t;
    geom_t   g;
    t        = get_timing(m);
    g.h_last = t.h_total - cnt_t'(1);
    g.hs_end = t.h_sync;
    g.ha_beg = t.h_sync + t.h_bp;
    g.ha_end = t.h_total - t.h_fp;
    g.v_last = t.v_total - cnt_t'(1);
    g.vs_end = t.v_sync;
    g.va_beg = t.v_sync + t.v_bp;
    g.va_end = t.v_total - t.v_fp;
    return g;
  endfunction

  // Active sync level of a mode; with polarity disabled every mode is active-high.
  function automatic logic hs_level(input mode_t m, input logic pol_en);
    return pol_en ? TIMING[m].hpol : 1'b1;
  endfunction

  function automatic logic vs_level(input mode_t m, input logic pol_en);
    return pol_en ? TIMING[m].vpol : 1'b1;
  endfunction

endpackage

// File: rtl/sync_vg_cnt.sv
// Horizontal/vertical position counter pair with frame wrap, a clear input and
// combinational region decodes of the current position.
module sync_vg_cnt
  import sync_vg_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  geom_t             geom,
  input  logic              adv,
  input  logic              clr,
  output logic [X_BITS-1:0] h,
  output logic [Y_BITS-1:0] v,
  output logic              frame_end,
  output logic              in_hs,
  output logic              in_vs,
  output logic              in_de
);

  logic line_end;

  assign line_end  = (h == X_BITS'(geom.h_last));
  assign frame_end = line_end && (v == Y_BITS'(geom.v_last));

  assign in_hs = (h < X_BITS'(geom.hs_end));
  assign in_vs = (v < Y_BITS'(geom.vs_end));
  assign in_de = (h >= X_BITS'(geom.ha_beg)) && (h < X_BITS'(geom.ha_end)) &&
                 (v >= Y_BITS'(geom.va_beg)) && (v < Y_BITS'(geom.va_end));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h <= '0;
      v <= '0;
    end else if (clr) begin
      h <= '0;
      v <= '0;
    end else if (adv) begin
      if (line_end) begin
        h <= '0;
        v <= frame_end ? '0 : v + Y_BITS'(1);
      end else begin
        h <= h + X_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/sync_vg_multi.sv
// Runtime-switchable video timing generator: four preset modes, frame-aligned mode
// changes, per-mode sync polarity, registered outputs one clock behind the counters.
module sync_vg_multi
  import sync_vg_pkg::*;
#(
  parameter int         X_BITS       = 12,
  parameter int         Y_BITS       = 12,
  parameter logic [1:0] DEFAULT_MODE = 2'd0,
  parameter bit         POL_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [1:0]        mode_i,
  output logic [1:0]        mode_o,
  output logic              switching,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] x_act,
  output logic [Y_BITS-1:0] y_act,
  output logic              frame_start,
  output logic              line_start
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam mode_t RST_MODE = mode_t'(DEFAULT_MODE);

  state_t            state_q;
  mode_t             mode_q;
  mode_t             pend_q;
  mode_t             mode_d;
  geom_t             geom;
  logic              live;
  logic [X_BITS-1:0] h;
  logic [Y_BITS-1:0] v;
  logic              frame_end;
  logic              in_hs;
  logic              in_vs;
  logic              in_de;

  assign geom = get_geom(mode_q);
  assign live = (state_q == ST_RUN) && en;

  // A pending mode is adopted while idle, or at the last pixel of a frame so the
  // counters wrap straight into the new table and no partial frame is produced.
  assign mode_d = ((state_q == ST_IDLE) || frame_end) ? pend_q : mode_q;

  sync_vg_cnt #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .geom     (geom),
    .adv      (live),
    .clr      (!live),
    .h        (h),
    .v        (v),
    .frame_end(frame_end),
    .in_hs    (in_hs),
    .in_vs    (in_vs),
    .in_de    (in_de)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      mode_q      <= RST_MODE;
      pend_q      <= RST_MODE;
      hs_out      <= ~hs_level(RST_MODE, POL_EN);
      vs_out      <= ~vs_level(RST_MODE, POL_EN);
      de_out      <= 1'b0;
      x_act       <= '0;
      y_act       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      pend_q <= mode_t'(mode_i);
      mode_q <= mode_d;

      case (state_q)
        ST_IDLE: if (en) state_q <= ST_RUN;
        ST_RUN:  if (!en) state_q <= ST_IDLE;
      endcase

      if (live) begin
        hs_out      <= in_hs ? hs_level(mode_q, POL_EN) : ~hs_level(mode_q, POL_EN);
        vs_out      <= in_vs ? vs_level(mode_q, POL_EN) : ~vs_level(mode_q, POL_EN);
        de_out      <= in_de;
        x_act       <= in_de ? h - X_BITS'(geom.ha_beg) : '0;
        y_act       <= in_de ? v - Y_BITS'(geom.va_beg) : '0;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
      end else begin
        // Idle syncs sit at the inactive level of the mode that is in force next cycle.
        hs_out      <= ~hs_level(mode_d, POL_EN);
        vs_out      <= ~vs_level(mode_d, POL_EN);
        de_out      <= 1'b0;
        x_act       <= '0;
        y_act       <= '0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

  assign mode_o    = mode_q;
  assign switching = (pend_q != mode_q);

endmodule
